mux_scan_ctrl: RTL and testbench

- Upstream controller for the 4:1 single-bit channel mux: drives the mux's 2-bit select and captures the mux's 1-bit output.
- On a start request it steps through the enabled channels in ascending order. It holds each select value for a programmable dwell time so the mux path can settle, then samples the result.
- It assembles a 4-bit snapshot of the sampled channels and signals completion with a one-cycle done pulse.

---
 rtl/mux_scan_ctrl_if.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 114 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Request/select/capture bundle between scan requester, mux
//               and mux_scan_ctrl.
// Revision    : 1.0
// ============================================================================
interface mux_scan_ctrl_if;
    logic       start;
    logic [3:0] mask;
    logic       y_in;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       busy;
    logic       done;

    modport master (
        output start, mask, y_in,
        input  sel, sample, busy, done
    );

    modport slave (
        input  start, mask, y_in,
        output sel, sample, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps a 4:1 mux through enabled channels, dwelling DWELL
//               cycles on each, and captures the mux output into a snapshot.
// Revision    : 1.0
// ============================================================================
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_scan_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [3:0]       r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_sample;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_first;
    logic [1:0]       w_next;
    logic             w_has_next;

    // Descending search so the last hit wins: lowest qualifying channel.
    always_comb begin
        w_first    = 2'd0;
        w_next     = r_sel;
        w_has_next = 1'b0;
        for (int j = 3; j >= 0; j--) begin
            if (bus.mask[j]) begin
                w_first = 2'(j);
            end
            if (r_mask[j] && (j > int'(r_sel))) begin
                w_next     = 2'(j);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mask   <= 4'd0;
            r_cnt    <= '0;
            r_sel    <= 2'd0;
            r_sample <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sample <= 4'd0;
                        if (bus.mask != 4'd0) begin
                            r_mask  <= bus.mask;
                            r_sel   <= w_first;
                            r_cnt   <= c_cnt_init;
                            r_busy  <= 1'b1;
                            r_state <= SETTLE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_sample[r_sel] <= bus.y_in;
                        if (w_has_next) begin
                            r_sel <= w_next;
                            r_cnt <= c_cnt_init;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel    = r_sel;
    assign bus.sample = r_sample;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Directed self-checking bench for mux_scan_ctrl (DWELL 2 and 1).
// Revision    : 1.0
// ============================================================================
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] mux_i2;
    logic [3:0] mux_i1;
    int         checks;
    int         errors;

    mux_scan_ctrl_if bus2 ();
    mux_scan_ctrl_if bus1 ();

    // Behavioural 4:1 mux in each loop
    assign bus2.y_in = mux_i2[bus2.sel];
    assign bus1.y_in = mux_i1[bus1.sel];

    mux_scan_ctrl #(.DWELL(2), .CNT_W(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    mux_scan_ctrl #(.DWELL(1), .CNT_W(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full scan on the DWELL=2 instance; optionally disturbs start/mask mid-scan.
    task automatic scan2(input logic [3:0] m, input logic [3:0] mi,
                         input logic [3:0] exp_s, input bit inject);
        logic [1:0] last;
        last        = 2'd0;
        mux_i2      = mi;
        bus2.start  = 1'b1;
        bus2.mask   = m;
        @(posedge clk);
        @(negedge clk);
        bus2.start  = inject;
        bus2.mask   = inject ? ~m : m;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                for (int d = 0; d < 2; d++) begin
                    check("scan_sel",  32'(bus2.sel), 32'(ch));
                    check("scan_busy", 32'(bus2.busy), 32'd1);
                    check("scan_done", 32'(bus2.done), 32'd0);
                    last = 2'(ch);
                    @(negedge clk);
                    bus2.start = 1'b0;
                end
            end
        end
        check("end_done",   32'(bus2.done), 32'd1);
        check("end_busy",   32'(bus2.busy), 32'd0);
        check("end_sample", 32'(bus2.sample), 32'(exp_s));
        if (m != 4'd0) check("end_sel", 32'(bus2.sel), 32'(last));
        @(negedge clk);
        check("post_done",   32'(bus2.done), 32'd0);
        check("post_busy",   32'(bus2.busy), 32'd0);
        check("post_sample", 32'(bus2.sample), 32'(exp_s));
        @(negedge clk);
        check("idle_done", 32'(bus2.done), 32'd0);
        check("idle_busy", 32'(bus2.busy), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        mux_i2     = 4'd0;
        mux_i1     = 4'd0;
        bus2.start = 1'b0;
        bus2.mask  = 4'd0;
        bus1.start = 1'b0;
        bus1.mask  = 4'd0;
        repeat (3) @(negedge clk);

        check("rst_sel",    32'(bus2.sel), 32'd0);
        check("rst_sample", 32'(bus2.sample), 32'd0);
        check("rst_busy",   32'(bus2.busy), 32'd0);
        check("rst_done",   32'(bus2.done), 32'd0);
        check("rst1_done",  32'(bus1.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        scan2(4'b1111, 4'b1010, 4'b1010, 1'b0);
        scan2(4'b0101, 4'b0111, 4'b0101, 1'b0);
        scan2(4'b0000, 4'b1111, 4'b0000, 1'b0);
        scan2(4'b1011, 4'b0110, 4'b0010, 1'b1);

        // Asynchronous reset during the third dwell cycle
        mux_i2     = 4'b1111;
        bus2.start = 1'b1;
        bus2.mask  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_sel",    32'(bus2.sel), 32'd1);
        check("mid_sample", 32'(bus2.sample), 32'b0001);
        check("mid_busy",   32'(bus2.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel",    32'(bus2.sel), 32'd0);
        check("arst_sample", 32'(bus2.sample), 32'd0);
        check("arst_busy",   32'(bus2.busy), 32'd0);
        check("arst_done",   32'(bus2.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan2(4'b1111, 4'b0101, 4'b0101, 1'b0);

        // DWELL=1 with start held high across two scans
        mux_i1     = 4'b1001;
        bus1.start = 1'b1;
        bus1.mask  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            check("d1_sel",  32'(bus1.sel), 32'(ch));
            check("d1_busy", 32'(bus1.busy), 32'd1);
            @(negedge clk);
        end
        check("d1_done",   32'(bus1.done), 32'd1);
        check("d1_sample", 32'(bus1.sample), 32'b1001);
        @(negedge clk);
        check("d1_idle_done",   32'(bus1.done), 32'd0);
        check("d1_idle_busy",   32'(bus1.busy), 32'd0);
        check("d1_idle_sample", 32'(bus1.sample), 32'b1001);
        @(negedge clk);
        check("d1_re_busy",   32'(bus1.busy), 32'd1);
        check("d1_re_sel",    32'(bus1.sel), 32'd0);
        check("d1_re_sample", 32'(bus1.sample), 32'd0);
        bus1.start = 1'b0;
        mux_i1     = 4'b0110;
        for (int ch = 1; ch < 4; ch++) begin
            @(negedge clk);
            check("d1_re_step", 32'(bus1.sel), 32'(ch));
        end
        @(negedge clk);
        check("d1_re_done",   32'(bus1.done), 32'd1);
        check("d1_re_result", 32'(bus1.sample), 32'b0110);
        @(negedge clk);
        check("d1_re_end", 32'(bus1.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
